// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution MAC unit.
// Optional build macro: CONV_MAC_SATURATE_EN (see conv_mac_unit).
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    OUT
  } conv_state_t;

  function automatic int num_passes(input int size, input int lanes);
    return (size + lanes - 1) / lanes;
  endfunction

  function automatic int acc_width(input int width, input int size);
    return 2 * width + $clog2(size);
  endfunction

endpackage

// File: rtl/mac_lane_array.sv
// Combinational bank of LANES multipliers summed at full accumulator width.
// Disabled lanes (padding past SIZE) contribute zero.
module mac_lane_array #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 3,
  parameter int ACC_WIDTH = 68
) (
  input  logic [LANES-1:0][WIDTH-1:0] kernel_i,
  input  logic [LANES-1:0][WIDTH-1:0] patch_i,
  input  logic [LANES-1:0]            en_i,
  output logic [ACC_WIDTH-1:0]        sum_o
);

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      if (en_i[l]) begin
        sum_o = sum_o
              + ACC_WIDTH'(kernel_i[l]) * ACC_WIDTH'(patch_i[l]);
      end
    end
  end

endmodule

// File: rtl/conv_mac_unit.sv
// Multi-pass dot product of a SIZE-element kernel and patch on LANES multipliers.
// Define CONV_MAC_SATURATE_EN to saturate y and flag ovf instead of wrapping.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 9,
  parameter int LANES     = 3,
  parameter int ACC_WIDTH = acc_width(WIDTH, SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIZE-1:0][WIDTH-1:0] kernel,
  input  logic [SIZE-1:0][WIDTH-1:0] patch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      ovf
);

  localparam int P  = num_passes(SIZE, LANES);
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int NP = P * LANES;

  conv_state_t                state_q;
  logic [PW-1:0]              pass_q;
  logic [SIZE-1:0][WIDTH-1:0] kernel_q;
  logic [SIZE-1:0][WIDTH-1:0] patch_q;
  logic [ACC_WIDTH-1:0]       acc_q;
  logic [WIDTH-1:0]           y_q;
  logic                       ovf_q;
  logic                       in_ready_q;
  logic                       out_valid_q;

  logic [NP-1:0][WIDTH-1:0]    kpad;
  logic [NP-1:0][WIDTH-1:0]    ppad;
  logic [NP-1:0]               en_pad;
  logic [LANES-1:0][WIDTH-1:0] lane_k;
  logic [LANES-1:0][WIDTH-1:0] lane_p;
  logic [LANES-1:0]            lane_en;
  logic [ACC_WIDTH-1:0]        lane_sum;
  logic [ACC_WIDTH-1:0]        acc_d;
  logic [WIDTH-1:0]            y_d;
  logic                        ovf_d;

  // Operands padded out to a whole number of passes; pad slots are masked.
  for (genvar i = 0; i < NP; i++) begin : g_pad
    if (i < SIZE) begin : g_real
      assign kpad[i]   = kernel_q[i];
      assign ppad[i]   = patch_q[i];
      assign en_pad[i] = 1'b1;
    end else begin : g_zero
      assign kpad[i]   = '0;
      assign ppad[i]   = '0;
      assign en_pad[i] = 1'b0;
    end
  end

  always_comb begin
    lane_k  = '0;
    lane_p  = '0;
    lane_en = '0;
    for (int p = 0; p < P; p++) begin
      if (pass_q == PW'(p)) begin
        for (int l = 0; l < LANES; l++) begin
          lane_k[l]  = kpad[p*LANES+l];
          lane_p[l]  = ppad[p*LANES+l];
          lane_en[l] = en_pad[p*LANES+l];
        end
      end
    end
  end

  mac_lane_array #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_lanes (
    .kernel_i (lane_k),
    .patch_i  (lane_p),
    .en_i     (lane_en),
    .sum_o    (lane_sum)
  );

  assign acc_d = acc_q + lane_sum;

  always_comb begin
`ifdef CONV_MAC_SATURATE_EN
    ovf_d = |acc_d[ACC_WIDTH-1:WIDTH];
    y_d   = ovf_d ? '1 : acc_d[WIDTH-1:0];
`else
    ovf_d = 1'b0;
    y_d   = acc_d[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      kernel_q    <= '0;
      patch_q     <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            kernel_q   <= kernel;
            patch_q    <= patch;
            acc_q      <= '0;
            pass_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q  <= acc_d;
          pass_q <= pass_q + 1'b1;
          if (pass_q == PW'(P - 1)) begin
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Scoreboard bench for conv_mac_unit: LANES=3 and a padded LANES=4 instance.
// Expected results come from a reference dot-product model.
module tb_conv_mac_unit;

  localparam int W = 8;
  localparam int S = 9;

  typedef logic [S-1:0][W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  vec_t         kernel;
  vec_t         patch;
  logic         in_ready3, out_valid3, ovf3;
  logic         in_ready4, out_valid4, ovf4;
  logic [W-1:0] y3, y4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W:0] q3[$];
  logic [W:0] q4[$];
  int         rises[$];
  logic       ov3_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_unit #(.WIDTH(W), .SIZE(S), .LANES(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .kernel    (kernel),
    .patch     (patch),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .y         (y3),
    .ovf       (ovf3)
  );

  conv_mac_unit #(.WIDTH(W), .SIZE(S), .LANES(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .kernel    (kernel),
    .patch     (patch),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .y         (y4),
    .ovf       (ovf4)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input vec_t k, input vec_t p);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < S; i++) s += 64'(k[i]) * 64'(p[i]);
`ifdef CONV_MAC_SATURATE_EN
    if (s > 64'(255)) return {1'b1, 8'hFF};
`endif
    return {1'b0, s[W-1:0]};
  endfunction

  function automatic vec_t fill(input int v);
    vec_t r;
    for (int i = 0; i < S; i++) r[i] = W'(v);
    return r;
  endfunction

  function automatic vec_t ramp();
    vec_t r;
    for (int i = 0; i < S; i++) r[i] = W'(i + 1);
    return r;
  endfunction

  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      q3.delete();
      q4.delete();
      ov3_prev = 1'b0;
    end else begin
      if (out_valid3 && out_ready) begin
        if (q3.size() == 0) check("sb3_empty", 1, 0);
        else begin
          e = q3.pop_front();
          check("y3", 64'(y3), 64'(e[W-1:0]));
          check("ovf3", 64'(ovf3), 64'(e[W]));
        end
      end
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) check("sb4_empty", 1, 0);
        else begin
          e = q4.pop_front();
          check("y4", 64'(y4), 64'(e[W-1:0]));
          check("ovf4", 64'(ovf4), 64'(e[W]));
        end
      end
      if (in_valid && in_ready3) q3.push_back(model(kernel, patch));
      if (in_valid && in_ready4) q4.push_back(model(kernel, patch));
      if (out_valid3 && !ov3_prev) rises.push_back(cyc);
      ov3_prev = out_valid3;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!in_ready3 && n < 20) begin
      step();
      n++;
    end
    if (!in_ready3) check("rdy_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q3.size() != 0 || q4.size() != 0 || out_valid3) && n < 40) begin
      step();
      n++;
    end
    if (q3.size() != 0 || q4.size() != 0) check("drain_timeout", 0, 1);
  endtask

  task automatic run_one(input vec_t k, input vec_t p);
    kernel   = k;
    patch    = p;
    in_valid = 1'b1;
    wait_rdy();
    step();
    in_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    kernel    = '0;
    patch     = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready3), 1);
    check("rst_out_valid", 64'(out_valid3), 0);
    check("rst_y", 64'(y3), 0);
    check("rst_ovf", 64'(ovf3), 0);

    // Basic: latency and ready timing
    out_ready = 1'b1;
    kernel    = fill(1);
    patch     = ramp();
    in_valid  = 1'b1;
    check("basic_rdy_T", 64'(in_ready3), 1);
    step();
    in_valid = 1'b0;
    kernel   = fill(7);
    check("basic_rdy_T1", 64'(in_ready3), 0);
    step();
    step();
    check("basic_ov_T3", 64'(out_valid3), 0);
    step();
    check("basic_ov_T4", 64'(out_valid3), 1);
    check("basic_ov4_T4", 64'(out_valid4), 1);
    check("basic_rdy_T4", 64'(in_ready3), 0);
    step();
    check("basic_rdy_T5", 64'(in_ready3), 1);
    check("basic_ov_T5", 64'(out_valid3), 0);
    wait_drain();

    // Padding: LANES=4 leaves three empty lanes in the last pass
    run_one(ramp(), fill(2));

    // Backpressure with the next vector already waiting
    out_ready = 1'b0;
    kernel    = fill(1);
    patch     = ramp();
    in_valid  = 1'b1;
    check("bp_rdy_T", 64'(in_ready3), 1);
    step();
    kernel = fill(2);
    patch  = fill(3);
    begin
      int n = 0;
      while (!out_valid3 && n < 20) begin
        step();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", 64'(out_valid3), 1);
      check("bp_y", 64'(y3), 45);
      check("bp_rdy", 64'(in_ready3), 0);
      step();
    end
    out_ready = 1'b1;
    check("bp_rdy_hs", 64'(in_ready3), 0);
    step();
    check("bp_rdy_after", 64'(in_ready3), 1);
    step();
    in_valid = 1'b0;
    wait_drain();

    // Overflow: 9 * 255 * 255 = 585225
    run_one(fill(255), fill(255));

    // Reset on the second MUL cycle
    kernel   = fill(1);
    patch    = fill(5);
    in_valid = 1'b1;
    check("abort_rdy_T", 64'(in_ready3), 1);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rdy", 64'(in_ready3), 1);
    check("abort_ov", 64'(out_valid3), 0);
    check("abort_y", 64'(y3), 0);
    check("abort_y4", 64'(y4), 0);
    check("abort_ovf", 64'(ovf3), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_out", 64'(out_valid3 | out_valid4), 0);
    end
    run_one(fill(1), ramp());

    // Back-to-back with in_valid and out_ready held high
    rises.delete();
    out_ready = 1'b1;
    kernel    = fill(1);
    patch     = ramp();
    in_valid  = 1'b1;
    check("b2b_rdy_T", 64'(in_ready3), 1);
    step();
    kernel = fill(2);
    patch  = fill(3);
    wait_rdy();
    step();
    in_valid = 1'b0;
    wait_drain();
    check("b2b_rises", 64'(rises.size()), 2);
    if (rises.size() == 2) check("b2b_gap", 64'(rises[1] - rises[0]), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
